// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, state encoding and helpers for the fetch stage.
package inst_fetch_pkg;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// inst_fetch_if_id_reg: IF/ID pipeline register; stall holds, flush loads a NOP bubble.
module inst_fetch_if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    logic [31:0] id_pc_d, id_pc_q, id_inst_d, id_inst_q;

    always_comb begin
        id_pc_d   = stall ? id_pc_q : flush ? ZERO_WORD : pc;
        id_inst_d = stall ? id_inst_q : flush ? NOP : inst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_q   <= ZERO_WORD;
            id_inst_q <= NOP;
        end else begin
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
        end
    end

    assign id_pc   = id_pc_q;
    assign id_inst = id_inst_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC sequencing with redirect, stall and deferred-redirect handling,
// feeding the IF/ID register.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jCe,
    input  logic [31:0] jAddr,
    input  logic [31:0] instruction,
    output logic        romCe,
    output logic [31:0] instAddr,
    output logic [31:0] idPc,
    output logic [31:0] idInst,
    output logic        addrErr
);

    state_t      state_d, state_q;
    logic [31:0] pc_d, pc_q, pend_d, pend_q;
    logic        err_d, err_q;
    logic        idle, run, pend, if_stall, if_flush;

    assign idle = state_q == IDLE;
    assign run  = state_q == RUN;
    assign pend = state_q == PEND;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= ZERO_WORD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Once a redirect is pending, later jCe pulses are ignored: first redirect wins.
    always_comb begin
        state_d = idle ? RUN : run ? ((stall && jCe) ? PEND : RUN) : (stall ? PEND : RUN);
        pc_d    = (idle || stall) ? pc_q : pend ? pend_q : jCe ? word_align(jAddr) : pc_q + 32'd4;
        pend_d  = (run && stall && jCe) ? word_align(jAddr) : pend_q;
        err_d   = run && jCe && (jAddr[1:0] != 2'b00);
    end

    always_comb begin
        romCe    = idle ? CHIP_DISABLE : CHIP_ENABLE;
        instAddr = idle ? RESET_PC : pc_q;
        if_stall = idle || stall;
        if_flush = pend || jCe;
    end

    assign addrErr = err_q;

    inst_fetch_if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .stall   (if_stall),
        .flush   (if_flush),
        .pc      (pc_q),
        .inst    (instruction),
        .id_pc   (idPc),
        .id_inst (idInst)
    );

endmodule
